sdp_ram_be: RTL and testbench

- Parametrised simple-dual-port RAM (one write port, one read port, one clock) with per-byte write enables and configurable read latency.
- Clears its contents by sequential scrub after reset; read-during-write collision behaviour is selectable.
- Next-generation on-chip buffer for datapath and FIFO blocks.

---
 rtl/sdp_ram_pkg.sv | 37 +++
 rtl/sdp_ram_rd_pipe.sv | 129 ++++++++++++
 rtl/sdp_ram_be.sv | 189 ++++++++++++++++++
 tb/tb_sdp_ram_be.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdp_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdp_ram_pkg
// Description : Shared types and helpers for the sdp_ram_be buffer.
//               - state_t         : controller states (SCRUB, READY)
//               - RDW_* constants : same-address read-during-write policy
//               - byte_merge()    : select new or old byte under a byte enable
//               - byte_parity()   : even-parity bit of one byte
// Revision    : 1.0 - initial release
// ============================================================================
package sdp_ram_pkg;

    typedef enum logic [0:0] {
        SCRUB = 1'b0,
        READY = 1'b1
    } state_t;

    // Collision policy when a read and a write hit the same address
    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    // Applied per byte lane so the helpers stay width-independent
    function automatic logic [7:0] byte_merge(
        input logic [7:0] i_old,
        input logic [7:0] i_new,
        input logic       i_be
    );
        return i_be ? i_new : i_old;
    endfunction

    // Stored bit makes the total count of ones in byte+bit even
    function automatic logic byte_parity(input logic [7:0] i_byte);
        return ^i_byte;
    endfunction

endpackage : sdp_ram_pkg
`default_nettype wire

// File: rtl/sdp_ram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sdp_ram_rd_pipe
// Description : Read response path of sdp_ram_be. Applies the collision
//               bypass to the raw array word, then registers the response
//               through RD_LAT stages (1 or 2) with valid tracking.
//               Optional feature macro: SDP_RAM_PARITY_EN (parity check).
// Ports       : clk, rst         - clock, synchronous active-high reset
//               i_rd_acc         - read accepted this cycle
//               i_rd_word        - array word at the read address (pre-write)
//               i_coll           - accepted write to the same address
//               i_wr_data/i_wr_be- write data and byte enables
//               i_rd_par/i_wr_par- stored / incoming parity (parity build)
//               o_rd_valid       - response strobe
//               o_rd_data        - response data, held between responses
//               o_par_err        - parity mismatch for this response
// Revision    : 1.0 - initial release
// ============================================================================
module sdp_ram_rd_pipe
    import sdp_ram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rd_acc,
    input  logic [DATA_W-1:0]     i_rd_word,
    input  logic                  i_coll,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic [DATA_W/8-1:0]   i_wr_be,
`ifdef SDP_RAM_PARITY_EN
    input  logic [DATA_W/8-1:0]   i_rd_par,
    input  logic [DATA_W/8-1:0]   i_wr_par,
`endif
    output logic                  o_rd_valid,
    output logic [DATA_W-1:0]     o_rd_data,
    output logic                  o_par_err
);

    localparam int NB = DATA_W / 8;

    // Only write-first lets the colliding write data reach the response
    logic              w_bypass;
    logic [DATA_W-1:0] w_s1_data;
    logic              w_s1_err;

    assign w_bypass = i_coll && (RDW_MODE == RDW_WRITE_FIRST);

    generate
        for (genvar b = 0; b < NB; b++) begin : g_lane
            assign w_s1_data[8*b +: 8] = byte_merge(i_rd_word[8*b +: 8],
                                                    i_wr_data[8*b +: 8],
                                                    i_wr_be[b] & w_bypass);
        end
    endgenerate

`ifdef SDP_RAM_PARITY_EN
    logic [NB-1:0] w_s1_par;
    logic [NB-1:0] w_lane_err;

    // Bypassed lanes take the parity being written alongside their data
    generate
        for (genvar b = 0; b < NB; b++) begin : g_par_lane
            assign w_s1_par[b]   = (i_wr_be[b] & w_bypass) ? i_wr_par[b] : i_rd_par[b];
            assign w_lane_err[b] = byte_parity(w_s1_data[8*b +: 8]) ^ w_s1_par[b];
        end
    endgenerate

    assign w_s1_err = |w_lane_err;
`else
    assign w_s1_err = 1'b0;
`endif

    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_par_err;

    generate
        if (RD_LAT == 1) begin : g_lat1
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_valid <= 1'b0;
                    r_rd_data  <= '0;
                    r_par_err  <= 1'b0;
                end else begin
                    r_rd_valid <= i_rd_acc;
                    r_par_err  <= i_rd_acc & w_s1_err;
                    if (i_rd_acc) begin
                        r_rd_data <= w_s1_data;
                    end
                end
            end
        end else begin : g_lat2
            logic              r_s1_valid;
            logic [DATA_W-1:0] r_s1_data;
            logic              r_s1_err;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1_valid <= 1'b0;
                    r_s1_data  <= '0;
                    r_s1_err   <= 1'b0;
                    r_rd_valid <= 1'b0;
                    r_rd_data  <= '0;
                    r_par_err  <= 1'b0;
                end else begin
                    r_s1_valid <= i_rd_acc;
                    r_s1_err   <= i_rd_acc & w_s1_err;
                    if (i_rd_acc) begin
                        r_s1_data <= w_s1_data;
                    end
                    r_rd_valid <= r_s1_valid;
                    r_par_err  <= r_s1_valid & r_s1_err;
                    if (r_s1_valid) begin
                        r_rd_data <= r_s1_data;
                    end
                end
            end
        end
    endgenerate

    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_par_err  = r_par_err;

endmodule : sdp_ram_rd_pipe
`default_nettype wire

// File: rtl/sdp_ram_be.sv
`default_nettype none
// ============================================================================
// Module      : sdp_ram_be
// Description : Simple-dual-port RAM, one clock, per-byte write enables,
//               read latency RD_LAT (1 or 2), selectable read-during-write
//               policy (RDW_MODE). After reset the array is scrubbed to zero
//               one word per cycle; ports are ignored until init_done.
//               Optional feature macro: SDP_RAM_PARITY_EN (per-byte parity,
//               inj_par_err test input, par_err flag).
// Ports       : clk, rst            - clock, synchronous active-high reset
//               init_done           - scrub complete, ports live
//               wr_en/wr_addr/wr_data/wr_be - write port
//               rd_en/rd_addr       - read request
//               rd_valid/rd_data    - read response
//               inj_par_err         - parity corruption on write (parity build)
//               par_err             - parity error on response (0 otherwise)
// Revision    : 1.0 - initial release
// ============================================================================
module sdp_ram_be
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_done,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
`ifdef SDP_RAM_PARITY_EN
    input  logic                  inj_par_err,
`endif
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  par_err
);

    import sdp_ram_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    // ------------------------------------------------------------------
    // Scrub / ready controller
    // ------------------------------------------------------------------
    state_t            r_state;
    logic [ADDR_W-1:0] r_scrub_ptr;
    logic              r_init_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= SCRUB;
            r_scrub_ptr <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                SCRUB: begin
                    r_scrub_ptr <= r_scrub_ptr + 1'b1;
                    if (r_scrub_ptr == {ADDR_W{1'b1}}) begin
                        r_state     <= READY;
                        r_init_done <= 1'b1;
                    end
                end
                READY: begin
                    r_state     <= READY;
                    r_init_done <= 1'b1;
                end
                default: begin
                    r_state     <= SCRUB;
                    r_init_done <= 1'b0;
                end
            endcase
        end
    end

    assign init_done = r_init_done;

    // ------------------------------------------------------------------
    // Array write port, shared by the scrubber and the user port
    // ------------------------------------------------------------------
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [NB-1:0]     w_mem_be;

    assign w_wr_acc = wr_en & r_init_done;
    assign w_rd_acc = rd_en & r_init_done;

    // Writes are suppressed on reset cycles so a request coinciding with
    // rst cannot land in the array.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = wr_addr;
        w_mem_wdata = wr_data;
        w_mem_be    = wr_be;
        if (!rst) begin
            if (r_state == SCRUB) begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_scrub_ptr;
                w_mem_wdata = '0;
                w_mem_be    = '1;
            end else if (w_wr_acc) begin
                w_mem_we    = 1'b1;
            end
        end
    end

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (w_mem_be[b]) begin
                    r_mem[w_mem_addr][8*b +: 8] <= w_mem_wdata[8*b +: 8];
                end
            end
        end
    end

    logic [DATA_W-1:0] w_rd_word;
    logic              w_coll;

    // Array read happens before this edge's write lands: this is the old word
    assign w_rd_word = r_mem[rd_addr];
    assign w_coll    = w_wr_acc & w_rd_acc & (wr_addr == rd_addr);

`ifdef SDP_RAM_PARITY_EN
    // ------------------------------------------------------------------
    // Parity storage: scrub writes 0, which matches the zeroed data
    // ------------------------------------------------------------------
    logic [NB-1:0] r_par [DEPTH];
    logic [NB-1:0] w_wr_par;
    logic [NB-1:0] w_mem_par;
    logic [NB-1:0] w_rd_par;

    generate
        for (genvar b = 0; b < NB; b++) begin : g_wr_par
            assign w_wr_par[b] = byte_parity(wr_data[8*b +: 8]) ^ inj_par_err;
        end
    endgenerate

    assign w_mem_par = (r_state == SCRUB) ? '0 : w_wr_par;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (w_mem_be[b]) begin
                    r_par[w_mem_addr][b] <= w_mem_par[b];
                end
            end
        end
    end

    assign w_rd_par = r_par[rd_addr];
`endif

    // ------------------------------------------------------------------
    // Read response pipeline
    // ------------------------------------------------------------------
    sdp_ram_rd_pipe #(
        .DATA_W   (DATA_W),
        .RD_LAT   (RD_LAT),
        .RDW_MODE (RDW_MODE)
    ) u_rd_pipe (
        .clk        (clk),
        .rst        (rst),
        .i_rd_acc   (w_rd_acc),
        .i_rd_word  (w_rd_word),
        .i_coll     (w_coll),
        .i_wr_data  (wr_data),
        .i_wr_be    (wr_be),
`ifdef SDP_RAM_PARITY_EN
        .i_rd_par   (w_rd_par),
        .i_wr_par   (w_wr_par),
`endif
        .o_rd_valid (rd_valid),
        .o_rd_data  (rd_data),
        .o_par_err  (par_err)
    );

endmodule : sdp_ram_be
`default_nettype wire

// File: tb/tb_sdp_ram_be.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdp_ram_be
// Description : Directed self-checking bench for sdp_ram_be. Two instances
//               share all inputs: u_a (RD_LAT=1, write-first) and
//               u_b (RD_LAT=2, read-first), both 32-bit x 16 words.
//               Parity checks are included when SDP_RAM_PARITY_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdp_ram_be;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        rd_en;
    logic [3:0]  rd_addr;
`ifdef SDP_RAM_PARITY_EN
    logic        inj_par_err;
`endif

    logic        a_init_done, a_rd_valid, a_par_err;
    logic [31:0] a_rd_data;
    logic        b_init_done, b_rd_valid, b_par_err;
    logic [31:0] b_rd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdp_ram_be #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(0)) u_a (
        .clk(clk), .rst(rst), .init_done(a_init_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr),
`ifdef SDP_RAM_PARITY_EN
        .inj_par_err(inj_par_err),
`endif
        .rd_valid(a_rd_valid), .rd_data(a_rd_data), .par_err(a_par_err)
    );

    sdp_ram_be #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .RDW_MODE(1)) u_b (
        .clk(clk), .rst(rst), .init_done(b_init_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr),
`ifdef SDP_RAM_PARITY_EN
        .inj_par_err(inj_par_err),
`endif
        .rd_valid(b_rd_valid), .rd_data(b_rd_data), .par_err(b_par_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = addr; wr_data = data; wr_be = be;
        step();
        wr_en = 1'b0;
    endtask

    // u_a answers one cycle after the request, u_b two cycles after
    task automatic do_read(input string tag, input logic [3:0] addr,
                           input logic [31:0] exp_a, input logic [31:0] exp_b,
                           input logic exp_pe);
        rd_en = 1'b1; rd_addr = addr;
        step();
        rd_en = 1'b0;
        chk({tag, " a_valid"}, 32'(a_rd_valid), 32'd1);
        chk({tag, " a_data"},  a_rd_data, exp_a);
        chk({tag, " a_perr"},  32'(a_par_err), 32'(exp_pe));
        chk({tag, " b_early"}, 32'(b_rd_valid), 32'd0);
        step();
        chk({tag, " a_drop"},  32'(a_rd_valid), 32'd0);
        chk({tag, " a_hold"},  a_rd_data, exp_a);
        chk({tag, " b_valid"}, 32'(b_rd_valid), 32'd1);
        chk({tag, " b_data"},  b_rd_data, exp_b);
        chk({tag, " b_perr"},  32'(b_par_err), 32'(exp_pe));
        step();
    endtask

    function automatic logic [31:0] stream_val(input int i);
        return 32'hC0DE_0000 | (32'(i) * 32'h0000_0111);
    endfunction

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;
`ifdef SDP_RAM_PARITY_EN
        inj_par_err = 1'b0;
`endif
        repeat (3) step();

        // Reset state
        chk("rst a_init",  32'(a_init_done), 32'd0);
        chk("rst a_valid", 32'(a_rd_valid),  32'd0);
        chk("rst a_data",  a_rd_data,        32'd0);
        chk("rst a_perr",  32'(a_par_err),   32'd0);
        chk("rst b_init",  32'(b_init_done), 32'd0);
        chk("rst b_valid", 32'(b_rd_valid),  32'd0);
        chk("rst b_data",  b_rd_data,        32'd0);

        // Scrub timing: init_done rises on the 16th edge after release;
        // a read issued on cycle 5 is ignored.
        rst = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            if (n == 5) begin
                rd_en = 1'b1; rd_addr = 4'd5;
            end
            step();
            rd_en = 1'b0;
            chk($sformatf("scrub a_init c%0d", n), 32'(a_init_done), 32'(n == 16));
            chk($sformatf("scrub b_init c%0d", n), 32'(b_init_done), 32'(n == 16));
            if (n >= 5 && n <= 8) begin
                chk($sformatf("scrub a_novalid c%0d", n), 32'(a_rd_valid), 32'd0);
                chk($sformatf("scrub b_novalid c%0d", n), 32'(b_rd_valid), 32'd0);
            end
        end

        do_read("zero@3",  4'd3,  32'd0, 32'd0, 1'b0);
        do_read("zero@15", 4'd15, 32'd0, 32'd0, 1'b0);

        // Byte enables, including the be=0 no-op
        do_write(4'd3, 32'hAABBCCDD, 4'hF);
        do_write(4'd3, 32'h11223344, 4'b0101);
        do_read("be@3", 4'd3, 32'hAA22CC44, 32'hAA22CC44, 1'b0);
        do_write(4'd3, 32'hDEADBEEF, 4'h0);
        do_read("be0@3", 4'd3, 32'hAA22CC44, 32'hAA22CC44, 1'b0);

        // Same-address collision
        do_write(4'd7, 32'h01020304, 4'hF);
        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hFFFFFFFF; wr_be = 4'b0011;
        rd_en = 1'b1; rd_addr = 4'd7;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("coll a_valid", 32'(a_rd_valid), 32'd1);
        chk("coll a_wf",    a_rd_data, 32'h0102FFFF);
        step();
        chk("coll b_valid", 32'(b_rd_valid), 32'd1);
        chk("coll b_rf",    b_rd_data, 32'h01020304);
        step();
        do_read("post_coll@7", 4'd7, 32'h0102FFFF, 32'h0102FFFF, 1'b0);

        // Different addresses in the same cycle are independent
        wr_en = 1'b1; wr_addr = 4'd8; wr_data = 32'h12345678; wr_be = 4'hF;
        do_read("indep@3", 4'd3, 32'hAA22CC44, 32'hAA22CC44, 1'b0);
        wr_en = 1'b0;
        do_read("indep@8", 4'd8, 32'h12345678, 32'h12345678, 1'b0);

        // Streaming: fill, then 16 back-to-back reads
        for (int i = 0; i < 16; i++) begin
            do_write(4'(i), stream_val(i), 4'hF);
        end
        for (int k = 0; k < 16; k++) begin
            rd_en = 1'b1; rd_addr = 4'(k);
            step();
            chk($sformatf("strm a_valid %0d", k), 32'(a_rd_valid), 32'd1);
            chk($sformatf("strm a_data %0d", k),  a_rd_data, stream_val(k));
            if (k > 0) begin
                chk($sformatf("strm b_valid %0d", k), 32'(b_rd_valid), 32'd1);
                chk($sformatf("strm b_data %0d", k),  b_rd_data, stream_val(k - 1));
            end else begin
                chk("strm b_valid first", 32'(b_rd_valid), 32'd0);
            end
        end
        rd_en = 1'b0;
        step();
        chk("strm a_end_valid", 32'(a_rd_valid), 32'd0);
        chk("strm a_hold",      a_rd_data, stream_val(15));
        chk("strm b_last",      b_rd_data, stream_val(15));
        chk("strm b_last_vld",  32'(b_rd_valid), 32'd1);
        step();
        chk("strm b_end_valid", 32'(b_rd_valid), 32'd0);
        chk("strm b_hold",      b_rd_data, stream_val(15));

`ifdef SDP_RAM_PARITY_EN
        // Corrupted parity is flagged, a clean rewrite clears it
        inj_par_err = 1'b1;
        do_write(4'd9, 32'h0F0F0F0F, 4'hF);
        inj_par_err = 1'b0;
        do_read("par_bad@9", 4'd9, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b1);
        do_write(4'd9, 32'h0F0F0F0F, 4'hF);
        do_read("par_ok@9", 4'd9, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0);
`endif

        // Reset mid-operation: read in flight at rst is dropped, second
        // rst during scrub cycle 8 restarts the scrub.
        do_write(4'd2, 32'h00000055, 4'hF);
        rd_en = 1'b1; rd_addr = 4'd2; rst = 1'b1;
        step();
        rd_en = 1'b0;
        chk("mid a_valid", 32'(a_rd_valid),  32'd0);
        chk("mid a_data",  a_rd_data,        32'd0);
        chk("mid a_init",  32'(a_init_done), 32'd0);
        step();
        chk("mid b_valid", 32'(b_rd_valid), 32'd0);
        chk("mid b_data",  b_rd_data,       32'd0);
        rst = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            step();
            chk($sformatf("mid scrub1 c%0d", n), 32'(a_init_done), 32'd0);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            step();
            chk($sformatf("mid scrub2 a c%0d", n), 32'(a_init_done), 32'(n == 16));
            chk($sformatf("mid scrub2 b c%0d", n), 32'(b_init_done), 32'(n == 16));
        end
        do_read("mid zero@2", 4'd2, 32'd0, 32'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sdp_ram_be
`default_nettype wire
